instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have: clr  in  1  reset; one clock; reset is synchronous and active-low.
REQ-003 SHALL have: IR_Data  in  32  instruction register contents; opcode = IR_Data[31:27].
REQ-004 SHALL have: CON_out  in  1  branch condition from CON FF logic.
REQ-005 SHALL have: Stop  in  1  request to halt after the current instruction.
REQ-006 SHALL have register-input strobes, all out 1: PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in.
REQ-007 SHALL have bus-drive strobes, all out 1: PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out.
REQ-008 SHALL have: Read, Write, Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  memory and select/encode controls.
REQ-009 SHALL have: alu_instruction_bits  out  5  ALU operation code; Run  out  1  high while executing.

Function
REQ-010 States SHALL be IDLE, T0..T7, HALT; one T-state per clock cycle.
REQ-011 Outputs SHALL be Moore: decoded from present state and latched opcode only; every strobe not listed for a state is 0; alu_instruction_bits 0 unless listed.
REQ-012 Fetch SHALL be T0: PC_out MAR_in IncPC Z_in; T1: Zlow_out PC_in Read MDR_in; T2: MDR_out IR_in.
REQ-013 Opcode SHALL be latched from IR_Data at the end of T2 and used for T3..T7.
REQ-014 add/sub/and/or/ror/rol/shr/shra/shl SHALL run T3: Grb Rout Y_in; T4: Grc Rout Z_in alu=opcode; T5: Zlow_out Gra Rin.
REQ-015 addi/andi/ori SHALL run T3: Grb Rout Y_in; T4: C_out Z_in alu=add/and/or code (00011/00101/00110); T5: Zlow_out Gra Rin.
REQ-016 mul/div SHALL run T3: Gra Rout Y_in; T4: Grb Rout Z_in alu=opcode; T5: Zlow_out LO_in; T6: Zhigh_out HI_in.
REQ-017 neg/not SHALL run T3: Grb Rout Z_in alu=opcode; T4: Zlow_out Gra Rin.
REQ-018 ld/ldi/st SHALL run T3: Grb BAout Y_in; T4: C_out Z_in alu=00011; ldi T5: Zlow_out Gra Rin.
REQ-019 ld SHALL continue T5: Zlow_out MAR_in; T6: Read MDR_in; T7: MDR_out Gra Rin.
REQ-020 st SHALL continue T5: Zlow_out MAR_in; T6: Gra Rout MDR_in; T7: Write.
REQ-021 br SHALL run T3: Gra Rout CON_in; T4: PC_out Y_in; T5: C_out Z_in alu=00011; T6: Zlow_out, PC_in = CON_out sampled in T6.
REQ-022 jr T3: Gra Rout PC_in; in T3: InPort_out Gra Rin; out T3: Gra Rout OutPort_in; mfhi T3: HI_out Gra Rin; mflo T3: LO_out Gra Rin.
REQ-023 nop and unassigned opcodes SHALL return to T0 after T2; halt SHALL enter HALT after T2.
REQ-024 After an instruction's last T-state next state SHALL be T0, or HALT if Stop was high on any edge since that instruction's T0.
REQ-025 HALT SHALL hold all strobes 0, Run 0, until reset; Stop has no effect in IDLE/HALT.
REQ-026 Opcodes SHALL follow the Mini SRC map: ld 00000 ... add 00011 ... br 10011, jr 10100, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.

Reset
REQ-027 clr=0 at a rising edge SHALL force IDLE, clear latched opcode and Stop request, all outputs 0, Run 0, regardless of current state.
REQ-028 First rising edge with clr=1 SHALL move IDLE to T0; Run SHALL be 1 in T0..T7.

Structure
REQ-029 Opcode constants, ALU codes and state encoding SHALL live in a shared package used by datapath and ALU.
REQ-030 One sub-module, seq_decode (combinational state+opcode -> strobes), SHALL be separated from the state register.

Verification
REQ-031 Reset then IR_Data=add R1,R2,R3 -> T0..T5 strobes per REQ-012/014, alu=00011 in T4, back to T0 at cycle 7.
REQ-032 br with CON_out=0 in T6 -> Zlow_out=1, PC_in=0; repeat with CON_out=1 -> PC_in=1.
REQ-033 ld -> Read=1 in T1 and T6, MDR_out+Gra+Rin in T7, next state T0.
REQ-034 st -> Write=1 only in T7; Read=0 throughout T3..T7.
REQ-035 Stop pulsed in T4 of mul -> T6 completes HI_in=1, then HALT, Run=0, strobes 0 for 10+ cycles.
REQ-036 clr=0 asserted in T5 of ldi -> next cycle IDLE, Rin=0; release -> T0 fetch restarts.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared Mini SRC definitions: opcodes, ALU codes, sequencer states and the
// control-word layout used by the sequencer, datapath and ALU.
package instruction_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_AND = OP_AND;
    localparam logic [4:0] ALU_OR  = OP_OR;

    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_t;

    typedef struct packed {
        logic       pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in;
        logic       out_port_in, inc_pc, con_in;
        logic       pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out;
        logic       in_port_out, c_out;
        logic       read, write, gra, grb, grc, rin, rout, ba_out;
        logic [4:0] alu;
        logic       run;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  return C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:         return C_IMM;
            OP_MUL, OP_DIV:                   return C_MULDIV;
            OP_NEG, OP_NOT:                   return C_UNARY;
            OP_LD:                            return C_LD;
            OP_LDI:                           return C_LDI;
            OP_ST:                            return C_ST;
            OP_BR:                            return C_BR;
            OP_JR:                            return C_JR;
            OP_IN:                            return C_IN;
            OP_OUT:                           return C_OUT;
            OP_MFHI:                          return C_MFHI;
            OP_MFLO:                          return C_MFLO;
            OP_HALT:                          return C_HALT;
            default:                          return C_NOP;
        endcase
    endfunction

    // Final T-state of each instruction class; nop/halt finish with the fetch.
    function automatic state_t last_state(input op_class_t c);
        case (c)
            C_ALU3, C_IMM, C_LDI:                 return S_T5;
            C_MULDIV, C_BR:                       return S_T6;
            C_UNARY:                              return S_T4;
            C_LD, C_ST:                           return S_T7;
            C_JR, C_IN, C_OUT, C_MFHI, C_MFLO:    return S_T3;
            default:                              return S_T2;
        endcase
    endfunction

    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Handshake between the control sequencer and the Mini SRC datapath.
interface instruction_sequencer_if;
    logic [31:0] IR_Data;
    logic        CON_out, Stop;
    logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in;
    logic        OutPort_in, IncPC, CON_in;
    logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out;
    logic        InPort_out, C_out;
    logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  alu_instruction_bits;
    logic        Run;

    modport master (
        input  IR_Data, CON_out, Stop,
        output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
               OutPort_in, IncPC, CON_in,
               PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
               InPort_out, C_out,
               Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
               alu_instruction_bits, Run
    );

    modport slave (
        output IR_Data, CON_out, Stop,
        input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
               OutPort_in, IncPC, CON_in,
               PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
               InPort_out, C_out,
               Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
               alu_instruction_bits, Run
    );
endinterface

// File: rtl/instruction_sequencer_seq_decode.sv
// Combinational control-word decode from the present T-state and latched opcode.
module seq_decode
    import instruction_sequencer_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con_out,
    output ctrl_t      ctrl
);
    op_class_t cls;
    assign cls = op_class(opcode);

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state != S_IDLE) && (state != S_HALT);
        case (state)
            S_T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1; end
            S_T1: begin ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
            S_T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
            S_T3: case (cls)
                C_ALU3, C_IMM: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                C_MULDIV:      begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                C_UNARY:       begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = opcode; end
                C_LD, C_LDI, C_ST: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                C_BR:          begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.con_in = 1'b1; end
                C_JR:          begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1; end
                C_IN:          begin ctrl.in_port_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                C_OUT:         begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.out_port_in = 1'b1; end
                C_MFHI:        begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                C_MFLO:        begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                default: ;
            endcase
            S_T4: case (cls)
                C_ALU3:        begin ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = opcode; end
                C_IMM:         begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = imm_alu(opcode); end
                C_MULDIV:      begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = opcode; end
                C_UNARY:       begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                C_LD, C_LDI, C_ST: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = ALU_ADD; end
                C_BR:          begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                default: ;
            endcase
            S_T5: case (cls)
                C_ALU3, C_IMM, C_LDI: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                C_MULDIV:      begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
                C_LD, C_ST:    begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
                C_BR:          begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = ALU_ADD; end
                default: ;
            endcase
            S_T6: case (cls)
                C_MULDIV:      begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
                C_LD:          begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
                C_ST:          begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdr_in = 1'b1; end
                C_BR:          begin ctrl.zlow_out = 1'b1; ctrl.pc_in = con_out; end
                default: ;
            endcase
            S_T7: case (cls)
                C_LD:          begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                C_ST:          ctrl.write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end
endmodule

// File: rtl/instruction_sequencer.sv
// Mini SRC control sequencer: T-state register, opcode latch and halt request,
// with strobe generation delegated to seq_decode.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
(
    input logic                      clk,
    input logic                      clr,
    instruction_sequencer_if.master  bus
);
    state_t     state_q, state_d;
    logic [4:0] opcode_q, opcode_d;
    logic       stop_q, stop_d;
    logic [4:0] cur_op;
    op_class_t  cur_cls;
    logic       halt_req;
    ctrl_t      ctrl;
    logic       unused_ir;

    // Only the opcode field of the instruction register steers sequencing.
    assign unused_ir = ^bus.IR_Data[26:0];

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            stop_q   <= stop_d;
        end
    end

    // In T2 the opcode is not latched yet, so sequencing reads it straight from IR.
    assign cur_op   = (state_q == S_T2) ? bus.IR_Data[31:27] : opcode_q;
    assign cur_cls  = op_class(cur_op);
    assign halt_req = stop_q | bus.Stop;

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        stop_d   = stop_q;
        case (state_q)
            S_IDLE: state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: begin
                stop_d = halt_req;
                if (state_q == S_T2)
                    opcode_d = bus.IR_Data[31:27];
                if (state_q == S_T2 && cur_cls == C_HALT) begin
                    state_d = S_HALT;
                end else if (state_q == last_state(cur_cls)) begin
                    state_d = halt_req ? S_HALT : S_T0;
                    stop_d  = 1'b0;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
        endcase
    end

    seq_decode u_decode (
        .state   (state_q),
        .opcode  (opcode_q),
        .con_out (bus.CON_out),
        .ctrl    (ctrl)
    );

    assign bus.PC_in                = ctrl.pc_in;
    assign bus.IR_in                = ctrl.ir_in;
    assign bus.Y_in                 = ctrl.y_in;
    assign bus.Z_in                 = ctrl.z_in;
    assign bus.HI_in                = ctrl.hi_in;
    assign bus.LO_in                = ctrl.lo_in;
    assign bus.MAR_in               = ctrl.mar_in;
    assign bus.MDR_in               = ctrl.mdr_in;
    assign bus.OutPort_in           = ctrl.out_port_in;
    assign bus.IncPC                = ctrl.inc_pc;
    assign bus.CON_in               = ctrl.con_in;
    assign bus.PC_out               = ctrl.pc_out;
    assign bus.Zhigh_out            = ctrl.zhigh_out;
    assign bus.Zlow_out             = ctrl.zlow_out;
    assign bus.HI_out               = ctrl.hi_out;
    assign bus.LO_out               = ctrl.lo_out;
    assign bus.MDR_out              = ctrl.mdr_out;
    assign bus.InPort_out           = ctrl.in_port_out;
    assign bus.C_out                = ctrl.c_out;
    assign bus.Read                 = ctrl.read;
    assign bus.Write                = ctrl.write;
    assign bus.Gra                  = ctrl.gra;
    assign bus.Grb                  = ctrl.grb;
    assign bus.Grc                  = ctrl.grc;
    assign bus.Rin                  = ctrl.rin;
    assign bus.Rout                 = ctrl.rout;
    assign bus.BAout                = ctrl.ba_out;
    assign bus.alu_instruction_bits = ctrl.alu;
    assign bus.Run                  = ctrl.run;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed vector bench for instruction_sequencer: a table of per-cycle
// {inputs, expected strobes} plus hand-written halt and reset sequences.
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    localparam logic [26:0] M_PC_IN    = 27'd1 << 26;
    localparam logic [26:0] M_IR_IN    = 27'd1 << 25;
    localparam logic [26:0] M_Y_IN     = 27'd1 << 24;
    localparam logic [26:0] M_Z_IN     = 27'd1 << 23;
    localparam logic [26:0] M_HI_IN    = 27'd1 << 22;
    localparam logic [26:0] M_LO_IN    = 27'd1 << 21;
    localparam logic [26:0] M_MAR_IN   = 27'd1 << 20;
    localparam logic [26:0] M_MDR_IN   = 27'd1 << 19;
    localparam logic [26:0] M_OUTP_IN  = 27'd1 << 18;
    localparam logic [26:0] M_INC_PC   = 27'd1 << 17;
    localparam logic [26:0] M_CON_IN   = 27'd1 << 16;
    localparam logic [26:0] M_PC_OUT   = 27'd1 << 15;
    localparam logic [26:0] M_ZHI_OUT  = 27'd1 << 14;
    localparam logic [26:0] M_ZLO_OUT  = 27'd1 << 13;
    localparam logic [26:0] M_HI_OUT   = 27'd1 << 12;
    localparam logic [26:0] M_LO_OUT   = 27'd1 << 11;
    localparam logic [26:0] M_MDR_OUT  = 27'd1 << 10;
    localparam logic [26:0] M_INP_OUT  = 27'd1 << 9;
    localparam logic [26:0] M_C_OUT    = 27'd1 << 8;
    localparam logic [26:0] M_READ     = 27'd1 << 7;
    localparam logic [26:0] M_WRITE    = 27'd1 << 6;
    localparam logic [26:0] M_GRA      = 27'd1 << 5;
    localparam logic [26:0] M_GRB      = 27'd1 << 4;
    localparam logic [26:0] M_GRC      = 27'd1 << 3;
    localparam logic [26:0] M_RIN      = 27'd1 << 2;
    localparam logic [26:0] M_ROUT     = 27'd1 << 1;
    localparam logic [26:0] M_BAOUT    = 27'd1 << 0;

    localparam logic [26:0] F0 = M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN;
    localparam logic [26:0] F1 = M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN;
    localparam logic [26:0] F2 = M_MDR_OUT | M_IR_IN;
    localparam logic [4:0]  OP_UNASSIGNED = 5'b10101;

    typedef struct {
        logic        clr;
        logic [4:0]  op;
        logic        con;
        logic        stop;
        logic        run;
        logic [4:0]  alu;
        logic [26:0] strb;
    } vec_t;

    logic clk;
    logic clr;
    int   n_vectors;
    int   n_miscompares;
    vec_t tbl[$];

    instruction_sequencer_if bus();

    instruction_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] got_strobes();
        return {bus.PC_in, bus.IR_in, bus.Y_in, bus.Z_in, bus.HI_in, bus.LO_in,
                bus.MAR_in, bus.MDR_in, bus.OutPort_in, bus.IncPC, bus.CON_in,
                bus.PC_out, bus.Zhigh_out, bus.Zlow_out, bus.HI_out, bus.LO_out,
                bus.MDR_out, bus.InPort_out, bus.C_out,
                bus.Read, bus.Write, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout};
    endfunction

    // Inputs go on before a rising edge; outputs are sampled 1ns after it.
    task automatic applyStimulus(input logic c, input logic [4:0] op, input logic con, input logic stop);
        clr         = c;
        bus.IR_Data = {op, 27'h12A51C3};
        bus.CON_out = con;
        bus.Stop    = stop;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int idx, input logic run,
                               input logic [4:0] alu, input logic [26:0] strb);
        logic [26:0] g;
        g = got_strobes();
        n_vectors++;
        if (bus.Run !== run || bus.alu_instruction_bits !== alu || g !== strb) begin
            n_miscompares++;
            $display("[TB] FAIL %s[%0d]: got run=%b alu=%b strb=%h, want run=%b alu=%b strb=%h",
                     tag, idx, bus.Run, bus.alu_instruction_bits, g, run, alu, strb);
        end
    endtask

    task automatic step(input string tag, input int idx, input logic c, input logic [4:0] op,
                        input logic stop, input logic run, input logic [4:0] alu, input logic [26:0] strb);
        applyStimulus(c, op, 1'b0, stop);
        checkOutput(tag, idx, run, alu, strb);
    endtask

    function automatic void vec(logic c, logic [4:0] op, logic con, logic stop,
                                logic run, logic [4:0] alu, logic [26:0] strb);
        vec_t v;
        v.clr = c; v.op = op; v.con = con; v.stop = stop;
        v.run = run; v.alu = alu; v.strb = strb;
        tbl.push_back(v);
    endfunction

    // IR still holds the previous instruction on the edge that enters T0.
    function automatic void fetch(logic [4:0] prev, logic [4:0] op);
        vec(1'b1, prev, 1'b0, 1'b0, 1'b1, 5'd0, F0);
        vec(1'b1, op,   1'b0, 1'b0, 1'b1, 5'd0, F1);
        vec(1'b1, op,   1'b0, 1'b0, 1'b1, 5'd0, F2);
    endfunction

    function automatic void t(logic [4:0] op, logic [4:0] alu, logic [26:0] strb);
        vec(1'b1, op, 1'b0, 1'b0, 1'b1, alu, strb);
    endfunction

    function automatic void build_table();
        vec(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 5'd0, 27'd0);
        fetch(OP_ADD, OP_ADD);
        t(OP_ADD, 5'd0,    M_GRB | M_ROUT | M_Y_IN);
        t(OP_ADD, 5'b00011, M_GRC | M_ROUT | M_Z_IN);
        t(OP_ADD, 5'd0,    M_ZLO_OUT | M_GRA | M_RIN);
        for (int k = 0; k < 2; k++) begin
            fetch(k == 0 ? OP_ADD : OP_BR, OP_BR);
            t(OP_BR, 5'd0,     M_GRA | M_ROUT | M_CON_IN);
            t(OP_BR, 5'd0,     M_PC_OUT | M_Y_IN);
            t(OP_BR, 5'b00011, M_C_OUT | M_Z_IN);
            vec(1'b1, OP_BR, k[0], 1'b0, 1'b1, 5'd0, (k == 0) ? M_ZLO_OUT : (M_ZLO_OUT | M_PC_IN));
        end
        fetch(OP_BR, OP_LD);
        t(OP_LD, 5'd0,     M_GRB | M_BAOUT | M_Y_IN);
        t(OP_LD, 5'b00011, M_C_OUT | M_Z_IN);
        t(OP_LD, 5'd0,     M_ZLO_OUT | M_MAR_IN);
        t(OP_LD, 5'd0,     M_READ | M_MDR_IN);
        t(OP_LD, 5'd0,     M_MDR_OUT | M_GRA | M_RIN);
        fetch(OP_LD, OP_ST);
        t(OP_ST, 5'd0,     M_GRB | M_BAOUT | M_Y_IN);
        t(OP_ST, 5'b00011, M_C_OUT | M_Z_IN);
        t(OP_ST, 5'd0,     M_ZLO_OUT | M_MAR_IN);
        t(OP_ST, 5'd0,     M_GRA | M_ROUT | M_MDR_IN);
        t(OP_ST, 5'd0,     M_WRITE);
        fetch(OP_ST, OP_ADDI);
        t(OP_ADDI, 5'd0,     M_GRB | M_ROUT | M_Y_IN);
        t(OP_ADDI, 5'b00011, M_C_OUT | M_Z_IN);
        t(OP_ADDI, 5'd0,     M_ZLO_OUT | M_GRA | M_RIN);
        fetch(OP_ADDI, OP_ORI);
        t(OP_ORI, 5'd0,     M_GRB | M_ROUT | M_Y_IN);
        t(OP_ORI, 5'b00110, M_C_OUT | M_Z_IN);
        t(OP_ORI, 5'd0,     M_ZLO_OUT | M_GRA | M_RIN);
        fetch(OP_ORI, OP_DIV);
        t(OP_DIV, 5'd0,     M_GRA | M_ROUT | M_Y_IN);
        t(OP_DIV, 5'b10000, M_GRB | M_ROUT | M_Z_IN);
        t(OP_DIV, 5'd0,     M_ZLO_OUT | M_LO_IN);
        t(OP_DIV, 5'd0,     M_ZHI_OUT | M_HI_IN);
        fetch(OP_DIV, OP_NEG);
        t(OP_NEG, 5'b10001, M_GRB | M_ROUT | M_Z_IN);
        t(OP_NEG, 5'd0,     M_ZLO_OUT | M_GRA | M_RIN);
        fetch(OP_NEG, OP_MFHI);
        t(OP_MFHI, 5'd0, M_HI_OUT | M_GRA | M_RIN);
        fetch(OP_MFHI, OP_IN);
        t(OP_IN, 5'd0, M_INP_OUT | M_GRA | M_RIN);
        fetch(OP_IN, OP_OUT);
        t(OP_OUT, 5'd0, M_GRA | M_ROUT | M_OUTP_IN);
        fetch(OP_OUT, OP_JR);
        t(OP_JR, 5'd0, M_GRA | M_ROUT | M_PC_IN);
        fetch(OP_JR, OP_NOP);
        fetch(OP_NOP, OP_UNASSIGNED);
    endfunction

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        clr           = 1'b0;
        bus.IR_Data   = '0;
        bus.CON_out   = 1'b0;
        bus.Stop      = 1'b0;
        build_table();

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].clr, tbl[i].op, tbl[i].con, tbl[i].stop);
            checkOutput("table", i, tbl[i].run, tbl[i].alu, tbl[i].strb);
        end

        // mul with Stop high during T4: finishes through T6, then parks in HALT.
        step("mul_stop", 0, 1'b1, OP_UNASSIGNED, 1'b0, 1'b1, 5'd0, F0);
        step("mul_stop", 1, 1'b1, OP_MUL, 1'b0, 1'b1, 5'd0, F1);
        step("mul_stop", 2, 1'b1, OP_MUL, 1'b0, 1'b1, 5'd0, F2);
        step("mul_stop", 3, 1'b1, OP_MUL, 1'b0, 1'b1, 5'd0, M_GRA | M_ROUT | M_Y_IN);
        step("mul_stop", 4, 1'b1, OP_MUL, 1'b0, 1'b1, 5'b01111, M_GRB | M_ROUT | M_Z_IN);
        step("mul_stop", 5, 1'b1, OP_MUL, 1'b1, 1'b1, 5'd0, M_ZLO_OUT | M_LO_IN);
        step("mul_stop", 6, 1'b1, OP_MUL, 1'b0, 1'b1, 5'd0, M_ZHI_OUT | M_HI_IN);
        for (int k = 0; k < 12; k++)
            step("halt_hold", k, 1'b1, OP_ADD, k[0], 1'b0, 5'd0, 27'd0);

        // Reset out of HALT, then clr dropped during T5 of ldi.
        step("ldi_clr", 0, 1'b0, OP_LDI, 1'b0, 1'b0, 5'd0, 27'd0);
        step("ldi_clr", 1, 1'b1, OP_LDI, 1'b0, 1'b1, 5'd0, F0);
        step("ldi_clr", 2, 1'b1, OP_LDI, 1'b0, 1'b1, 5'd0, F1);
        step("ldi_clr", 3, 1'b1, OP_LDI, 1'b0, 1'b1, 5'd0, F2);
        step("ldi_clr", 4, 1'b1, OP_LDI, 1'b0, 1'b1, 5'd0, M_GRB | M_BAOUT | M_Y_IN);
        step("ldi_clr", 5, 1'b1, OP_LDI, 1'b0, 1'b1, 5'b00011, M_C_OUT | M_Z_IN);
        step("ldi_clr", 6, 1'b1, OP_LDI, 1'b0, 1'b1, 5'd0, M_ZLO_OUT | M_GRA | M_RIN);
        step("ldi_clr", 7, 1'b0, OP_LDI, 1'b0, 1'b0, 5'd0, 27'd0);
        step("ldi_clr", 8, 1'b1, OP_LDI, 1'b0, 1'b1, 5'd0, F0);

        // halt opcode: fetch completes, then HALT with everything idle.
        step("halt_op", 0, 1'b1, OP_HALT, 1'b0, 1'b1, 5'd0, F1);
        step("halt_op", 1, 1'b1, OP_HALT, 1'b0, 1'b1, 5'd0, F2);
        for (int k = 2; k < 6; k++)
            step("halt_op", k, 1'b1, OP_HALT, 1'b0, 1'b0, 5'd0, 27'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
